io_port_hub: RTL and testbench
==============================

IO_PORT_HUB -- requirements
Module: io_port_hub

Interface
REQ-001 Parameter NPORT, default 4: number of processor I/O ports in each direction.
REQ-002 Parameter IN_W, default 16: processor input word width.
REQ-003 Parameter OUT_W, default 33: processor output word width.
REQ-004 Parameter DEPTH, default 4 (power of two, >=2): FIFO entries per port, each direction.
REQ-005 clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_in  input  NPORT  one-hot processor read strobe (port select).
REQ-008 io_in  output  IN_W  read data returned to the processor.
REQ-009 out_en  input  NPORT  one-hot processor write strobe (port select).
REQ-010 io_out  input  OUT_W  write data from the processor.
REQ-011 src_data  input  NPORT*IN_W  producer words; port p occupies bits [p*IN_W +: IN_W].
REQ-012 src_valid / src_ready  input / output  NPORT each  producer handshake, per port.
REQ-013 snk_data  output  NPORT*OUT_W  consumer words; port p occupies bits [p*OUT_W +: OUT_W].
REQ-014 snk_valid / snk_ready  output / input  NPORT each  consumer handshake, per port.
REQ-015 rd_underflow / wr_overflow  output  NPORT each  sticky error flags, per port.

Function
REQ-016 Each port SHALL have one input FIFO (producer to processor) and one output FIFO (processor to consumer), each DEPTH deep, first-in first-out, with a log2(DEPTH)+1-bit occupancy count.
REQ-017 Input push: when src_valid[p] and src_ready[p] are both high, the word SHALL be written; src_ready[p] = input FIFO p not full, OR full with a pop of port p in the same cycle.
REQ-018 Read select: the selected port SHALL be the lowest-index set bit of req_in; a multi-hot req_in SHALL act on that port only.
REQ-019 io_in SHALL combinationally present the head of the selected input FIFO in the same cycle; it SHALL be 0 when req_in is 0 or the selected FIFO is empty.
REQ-020 At the clock edge with req_in nonzero, the selected FIFO SHALL pop if non-empty; if empty, nothing pops and rd_underflow[p] SHALL set.
REQ-021 Write select: the lowest-index set bit of out_en selects the port; at the edge, io_out SHALL be pushed into output FIFO p.
REQ-022 Output FIFO full with no pop in the same cycle: the word SHALL be dropped, the contents left unchanged, and wr_overflow[p] SHALL set; full with a simultaneous pop: the push SHALL be accepted.
REQ-023 snk_valid[p] = output FIFO p non-empty; snk_data for port p = its head; pop SHALL occur when snk_valid[p] and snk_ready[p] are both high.
REQ-024 Simultaneous push and pop on a non-empty FIFO SHALL leave its count unchanged; on an empty FIFO the push SHALL occur and the pop SHALL not.
REQ-025 The latency from a write to the first visibility at the opposite side SHALL be one cycle in both directions.
REQ-026 Pointers SHALL wrap modulo DEPTH without loss of ordering.
REQ-027 Error flags SHALL remain set until rst.
REQ-028 Ports SHALL be fully independent: activity on port p SHALL not affect port q.

Reset
REQ-029 While rst is high at an edge, all FIFOs SHALL empty, pointers and counts SHALL go to 0, and error flags SHALL clear.
REQ-030 During and after reset: snk_valid = 0, io_in = 0 (when req_in = 0), src_ready = all ones.
REQ-031 rst SHALL override any simultaneous push or pop; a reset mid-transfer discards the in-flight words.

Verification
REQ-032 Loopback: push 0x1234 on src port 2, then req_in = 4'b0100 one cycle later -> io_in = 0x1234 that cycle, FIFO 2 empty after the edge.
REQ-033 Fill: push 4 words on port 0 with no reads -> src_ready[0] = 0; read and push in the same cycle -> accepted, count stays 4, order preserved.
REQ-034 Empty read on port 1 -> io_in = 0, rd_underflow = 4'b0010, remaining set after later valid traffic.
REQ-035 out_en = 4'b1000 with 5 writes and snk_ready[3] = 0 -> 4 words stored, 5th dropped, wr_overflow[3] = 1; then snk_ready high -> first 4 words out in order.
REQ-036 req_in = 4'b0110 with both FIFOs non-empty -> only port 1 pops, port 2 unchanged.
REQ-037 Assert rst with all FIFOs partially full -> next cycle all snk_valid = 0, all src_ready = 1, all flags = 0.

Source files
------------

// File: rtl/io_port_hub.sv
// rtl/io_port_hub.sv - per-port producer/consumer FIFOs bridging processor I/O strobes.
// Each port owns an input FIFO (producer -> processor) and an output FIFO (processor -> consumer).

module io_port_hub_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         nonempty_o,
    output logic         can_push_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign nonempty_o = (cnt_q != '0);
    assign full       = (cnt_q == CW'(DEPTH));
    assign do_pop     = pop_i & nonempty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_push_o = ~full | do_pop;
    assign do_push    = push_i & can_push_o;
    assign head_o     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module io_port_hub #(
    parameter int NPORT = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req_in,
    output logic [IN_W-1:0]        io_in,
    input  logic [NPORT-1:0]       out_en,
    input  logic [OUT_W-1:0]       io_out,
    input  logic [NPORT*IN_W-1:0]  src_data,
    input  logic [NPORT-1:0]       src_valid,
    output logic [NPORT-1:0]       src_ready,
    output logic [NPORT*OUT_W-1:0] snk_data,
    output logic [NPORT-1:0]       snk_valid,
    input  logic [NPORT-1:0]       snk_ready,
    output logic [NPORT-1:0]       rd_underflow,
    output logic [NPORT-1:0]       wr_overflow
);
    logic [NPORT-1:0] rd_sel;
    logic [NPORT-1:0] wr_sel;
    logic [IN_W-1:0]  in_head [NPORT];
    logic [NPORT-1:0] in_nonempty;
    logic [NPORT-1:0] out_can_push;
    logic [NPORT-1:0] ruf_q, ruf_d;
    logic [NPORT-1:0] wof_q, wof_d;

    // Isolate the lowest set bit so multi-hot strobes act on one port only.
    assign rd_sel = req_in & (~req_in + NPORT'(1));
    assign wr_sel = out_en & (~out_en + NPORT'(1));

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        io_port_hub_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_in_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (src_valid[p]),
            .data_i     (src_data[p*IN_W +: IN_W]),
            .pop_i      (rd_sel[p]),
            .head_o     (in_head[p]),
            .nonempty_o (in_nonempty[p]),
            .can_push_o (src_ready[p])
        );

        io_port_hub_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_out_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (wr_sel[p]),
            .data_i     (io_out),
            .pop_i      (snk_ready[p]),
            .head_o     (snk_data[p*OUT_W +: OUT_W]),
            .nonempty_o (snk_valid[p]),
            .can_push_o (out_can_push[p])
        );
    end

    always_comb begin
        io_in = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (rd_sel[p] && in_nonempty[p]) begin
                io_in = in_head[p];
            end
        end
    end

    always_comb begin
        ruf_d = ruf_q | (rd_sel & ~in_nonempty);
        wof_d = wof_q | (wr_sel & ~out_can_push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ruf_q <= '0;
            wof_q <= '0;
        end else begin
            ruf_q <= ruf_d;
            wof_q <= wof_d;
        end
    end

    assign rd_underflow = ruf_q;
    assign wr_overflow  = wof_q;
endmodule

// File: tb/tb_io_port_hub.sv
// tb/tb_io_port_hub.sv - directed table and sequence bench for io_port_hub.
module tb_io_port_hub;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_in;
    logic [15:0]  io_in;
    logic [3:0]   out_en;
    logic [32:0]  io_out;
    logic [63:0]  src_data;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [131:0] snk_data;
    logic [3:0]   snk_valid;
    logic [3:0]   snk_ready;
    logic [3:0]   rd_underflow;
    logic [3:0]   wr_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_port_hub #(.NPORT(4), .IN_W(16), .OUT_W(33), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .io_in        (io_in),
        .out_en       (out_en),
        .io_out       (io_out),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .snk_data     (snk_data),
        .snk_valid    (snk_valid),
        .snk_ready    (snk_ready),
        .rd_underflow (rd_underflow),
        .wr_overflow  (wr_overflow)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  oen;
        logic [32:0] wd;
        logic [3:0]  sv;
        logic [63:0] sd;
        logic [3:0]  sr;
        logic [15:0] e_io;
        logic [3:0]  e_srdy;
        logic [3:0]  e_svld;
        logic [3:0]  e_ruf;
        logic [3:0]  e_wof;
        int          e_port;
        logic [32:0] e_word;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] oen, input logic [32:0] wd,
                                input logic [3:0] sv, input logic [63:0] sd, input logic [3:0] sr,
                                input logic [15:0] e_io, input logic [3:0] e_srdy, input logic [3:0] e_svld,
                                input logic [3:0] e_ruf, input logic [3:0] e_wof, input int e_port,
                                input logic [32:0] e_word);
        vec_t v;
        v.req = req; v.oen = oen; v.wd = wd; v.sv = sv; v.sd = sd; v.sr = sr;
        v.e_io = e_io; v.e_srdy = e_srdy; v.e_svld = e_svld; v.e_ruf = e_ruf;
        v.e_wof = e_wof; v.e_port = e_port; v.e_word = e_word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        req_in = '0; out_en = '0; io_out = '0;
        src_valid = '0; src_data = '0; snk_ready = '0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();

        //          req   oen   wd              sv    sd                       sr     io       srdy  svld  ruf   wof   port word
        tbl.push_back(mk(4'h0, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h0,    4'hF, 4'h0, 4'h0, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h0, 4'h0, 33'h0,          4'h4, 64'h0000_1234_0000_0000, 4'h0, 16'h0,    4'hF, 4'h0, 4'h0, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h4, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h1234, 4'hF, 4'h0, 4'h0, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h2, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h0,    4'hF, 4'h0, 4'h0, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h0, 4'h1, 33'h1_0000_0001, 4'h0, 64'h0,                  4'h0, 16'h0,    4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h0, 4'h0, 33'h0,          4'h2, 64'h0000_0000_BEEF_0000, 4'h0, 16'h0,    4'hF, 4'h1, 4'h2, 4'h0, 0, 33'h1_0000_0001));
        tbl.push_back(mk(4'h2, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h1, 16'hBEEF, 4'hF, 4'h1, 4'h2, 4'h0, 0, 33'h1_0000_0001));
        tbl.push_back(mk(4'h0, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h0,    4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h0, 4'h0, 33'h0,          4'h6, 64'h0000_2222_1111_0000, 4'h0, 16'h0,    4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h6, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h1111, 4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h0, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h0,    4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h4, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h2222, 4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));
        tbl.push_back(mk(4'h2, 4'h0, 33'h0,          4'h0, 64'h0,                   4'h0, 16'h0,    4'hF, 4'h0, 4'h2, 4'h0, -1, 33'h0));

        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            req_in = tbl[i].req; out_en = tbl[i].oen; io_out = tbl[i].wd;
            src_valid = tbl[i].sv; src_data = tbl[i].sd; snk_ready = tbl[i].sr;
            #1;
            chk($sformatf("row%0d io_in", i), 64'(io_in), 64'(tbl[i].e_io));
            chk($sformatf("row%0d src_ready", i), 64'(src_ready), 64'(tbl[i].e_srdy));
            chk($sformatf("row%0d snk_valid", i), 64'(snk_valid), 64'(tbl[i].e_svld));
            chk($sformatf("row%0d rd_underflow", i), 64'(rd_underflow), 64'(tbl[i].e_ruf));
            chk($sformatf("row%0d wr_overflow", i), 64'(wr_overflow), 64'(tbl[i].e_wof));
            if (tbl[i].e_port >= 0)
                chk($sformatf("row%0d snk_data", i), 64'(snk_data[tbl[i].e_port*33 +: 33]), 64'(tbl[i].e_word));
            @(negedge clk);
        end

        // Fill input FIFO 0, then read+push while full, then drain across the pointer wrap.
        for (int i = 0; i < 4; i++) begin
            set_idle(); src_valid = 4'h1; src_data = 64'hA000 + 64'(i);
            @(negedge clk);
        end
        set_idle(); #1;
        chk("fill src_ready", 64'(src_ready), 64'hE);
        req_in = 4'h1; src_valid = 4'h1; src_data = 64'hA004; #1;
        chk("full rw io_in", 64'(io_in), 64'hA000);
        chk("full rw src_ready", 64'(src_ready), 64'hF);
        @(negedge clk);
        set_idle(); #1;
        chk("full rw count", 64'(src_ready), 64'hE);
        for (int i = 0; i < 4; i++) begin
            req_in = 4'h1; #1;
            chk($sformatf("drain0 %0d", i), 64'(io_in), 64'hA001 + 64'(i));
            @(negedge clk);
        end
        set_idle(); #1;
        chk("drain0 src_ready", 64'(src_ready), 64'hF);
        chk("sticky underflow", 64'(rd_underflow), 64'h2);

        // Output FIFO 3 overflow with consumer stalled.
        for (int i = 0; i < 5; i++) begin
            set_idle(); out_en = 4'h8; io_out = 33'h1_0000_0300 + 33'(i); #1;
            if (i == 4) chk("ovf pre", 64'(wr_overflow), 64'h0);
            @(negedge clk);
        end
        set_idle(); #1;
        chk("ovf flag", 64'(wr_overflow), 64'h8);
        chk("ovf snk_valid", 64'(snk_valid), 64'h8);
        for (int i = 0; i < 4; i++) begin
            snk_ready = 4'h8; #1;
            chk($sformatf("drain3 valid %0d", i), 64'(snk_valid[3]), 64'h1);
            chk($sformatf("drain3 data %0d", i), 64'(snk_data[99 +: 33]), 64'h1_0000_0300 + 64'(i));
            @(negedge clk);
        end
        set_idle(); #1;
        chk("drain3 empty", 64'(snk_valid), 64'h0);

        // Output FIFO 2: write while full and draining is accepted.
        for (int i = 0; i < 4; i++) begin
            set_idle(); out_en = 4'h4; io_out = 33'h200 + 33'(i);
            @(negedge clk);
        end
        out_en = 4'h4; io_out = 33'h204; snk_ready = 4'h4; #1;
        chk("full pop head", 64'(snk_data[66 +: 33]), 64'h200);
        @(negedge clk);
        set_idle(); #1;
        chk("full pop no ovf", 64'(wr_overflow), 64'h8);
        for (int i = 0; i < 4; i++) begin
            snk_ready = 4'h4; #1;
            chk($sformatf("drain2 data %0d", i), 64'(snk_data[66 +: 33]), 64'h201 + 64'(i));
            @(negedge clk);
        end

        // Reset with FIFOs partly full and traffic in flight.
        set_idle(); src_valid = 4'h9; src_data = 64'h5555_0000_0000_7777; out_en = 4'h2; io_out = 33'h5;
        @(negedge clk);
        set_idle(); rst = 1'b1; src_valid = 4'hF; src_data = 64'hFFFF_FFFF_FFFF_FFFF; out_en = 4'h1; #1;
        chk("pre-rst snk_valid", 64'(snk_valid), 64'h2);
        @(negedge clk);
        rst = 1'b0; set_idle(); #1;
        chk("rst snk_valid", 64'(snk_valid), 64'h0);
        chk("rst src_ready", 64'(src_ready), 64'hF);
        chk("rst rd_underflow", 64'(rd_underflow), 64'h0);
        chk("rst wr_overflow", 64'(wr_overflow), 64'h0);
        chk("rst io_in", 64'(io_in), 64'h0);
        req_in = 4'h9; #1;
        chk("rst discard io_in", 64'(io_in), 64'h0);
        @(negedge clk);
        set_idle(); #1;
        chk("post-rst underflow", 64'(rd_underflow), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
